// File: rtl/stream_queue_if.sv
// stream_queue_if: handshake bundle between an upstream producer, the queue and a downstream consumer
//   recv_msg/recv_val/recv_rdy : enqueue side (producer -> queue)
//   send_msg/send_val/send_rdy : dequeue side (queue -> consumer)
//   count                      : queue occupancy, 0..DEPTH
//   modport slave  : the queue itself
//   modport master : the environment driving and observing the queue
interface stream_queue_if #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4
);
    logic [BIT_WIDTH-1:0]     recv_msg;
    logic                     recv_val;
    logic                     recv_rdy;
    logic [BIT_WIDTH-1:0]     send_msg;
    logic                     send_val;
    logic                     send_rdy;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg, send_val, count
    );

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_val, count
    );
endinterface

// File: rtl/stream_queue.sv
// stream_queue: DEPTH-entry circular FIFO with valid/ready handshakes on both sides
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; clears pointers and occupancy only
//   q     : stream_queue_if.slave (recv_* enqueue side, send_* dequeue side, count)
module stream_queue #(
    parameter int BIT_WIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic            clk,
    input  logic            reset,
    stream_queue_if.slave   q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_head;
    logic [AW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic                 w_rdy;
    logic                 w_val;
    logic                 w_enq;
    logic                 w_deq;

    // Handshake outputs depend only on the occupancy register: no bypass, no pass-through.
    assign w_rdy = r_count != CW'(DEPTH);
    assign w_val = r_count != '0;
    assign w_enq = q.recv_val && w_rdy;
    assign w_deq = w_val && q.send_rdy;

    assign q.recv_rdy = w_rdy;
    assign q.send_val = w_val;
    assign q.send_msg = w_val ? r_mem[r_head] : '0;
    assign q.count    = r_count;

    // Storage is deliberately left out of reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= q.recv_msg;
    end

    // DEPTH is a power of two, so the AW-bit pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + AW'(1);
            if (w_deq) r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end
endmodule

// File: tb/tb_stream_queue.sv
// tb_stream_queue: randomized and directed checks of stream_queue against a queue-based reference model
module tb_stream_queue;
    localparam int BW = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int n_checks = 0;
    int n_fail = 0;
    logic [BW-1:0] ref_q [$];

    stream_queue_if #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) sq ();

    stream_queue #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, BW'(sq.count), BW'(ref_q.size()));
        check({tag, "_send_val"}, BW'(sq.send_val), BW'(ref_q.size() > 0));
        check({tag, "_recv_rdy"}, BW'(sq.recv_rdy), BW'(ref_q.size() < DEPTH));
        check({tag, "_send_msg"}, sq.send_msg, ref_q.size() > 0 ? ref_q[0] : '0);
    endtask

    task automatic step(input logic v, input logic [BW-1:0] m, input logic r);
        bit e;
        bit d;
        @(negedge clk);
        sq.recv_val = v;
        sq.recv_msg = m;
        sq.send_rdy = r;
        #1;
        e = v && ref_q.size() < DEPTH;
        d = r && ref_q.size() > 0;
        if (d) check("deq_data", sq.send_msg, ref_q[0]);
        @(posedge clk);
        #1;
        if (d) void'(ref_q.pop_front());
        if (e) ref_q.push_back(m);
        check_state("post");
    endtask

    task automatic idle(input logic r);
        step(1'b0, 'x, r);
    endtask

    initial begin
        reset = 1'b1;
        sq.recv_val = 1'b1;
        sq.recv_msg = 32'hDEAD_BEEF;
        sq.send_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("in_reset");
        #2;
        reset = 1'b0;

        // basic flow
        step(1'b1, 32'hA5A5_0001, 1'b0);
        check("basic_msg", sq.send_msg, 32'hA5A5_0001);
        check("basic_count", BW'(sq.count), 32'd1);
        idle(1'b1);

        // fill, overflow attempt, ordered drain
        for (int i = 1; i <= 4; i++) step(1'b1, BW'(i), 1'b0);
        check("fill_count", BW'(sq.count), 32'd4);
        check("fill_rdy", BW'(sq.recv_rdy), 32'd0);
        step(1'b1, 32'h5, 1'b0);
        check("overflow_count", BW'(sq.count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", sq.send_msg, BW'(i));
            idle(1'b1);
        end

        // full with simultaneous enqueue and dequeue: only dequeue happens
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + BW'(i), 1'b0);
        step(1'b1, 32'h77, 1'b1);
        check("full_both_count", BW'(sq.count), 32'd3);
        check("full_both_rdy", BW'(sq.recv_rdy), 32'd1);
        idle(1'b1);

        // streaming at count 2 across pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 32'h10 + BW'(i), 1'b1);
        check("stream_count", BW'(sq.count), 32'd2);
        check("stream_head", sq.send_msg, 32'h18);
        idle(1'b1);
        idle(1'b1);

        // asynchronous reset between edges with count 3
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + BW'(i), 1'b0);
        check("pre_reset_count", BW'(sq.count), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        ref_q.delete();
        check_state("async_reset");
        #1;
        reset = 1'b0;
        step(1'b1, 32'h55, 1'b0);
        check("post_reset_first", sq.send_msg, 32'h55);
        idle(1'b1);

        // dequeue attempts while empty
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("empty_msg", sq.send_msg, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_queue.md
STREAM_QUEUE -- requirements
Module: stream_queue

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: message width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port recv_msg, input, BIT_WIDTH: enqueue data from the upstream crossbar output port.
REQ-006 SHALL have port recv_val, input, 1: upstream valid.
REQ-007 SHALL have port recv_rdy, output, 1: queue can accept an entry.
REQ-008 SHALL have port send_msg, output, BIT_WIDTH: head-of-queue data.
REQ-009 SHALL have port send_val, output, 1: queue holds at least one entry.
REQ-010 SHALL have port send_rdy, input, 1: downstream ready.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

Function
REQ-012 SHALL enqueue when recv_val && recv_rdy at a rising clk edge; recv_msg is written at the tail and the tail pointer advances.
REQ-013 SHALL dequeue when send_val && send_rdy at a rising clk edge; the head pointer advances.
REQ-014 SHALL drive recv_rdy = (count != DEPTH), purely from registered state and independent of send_rdy (no full-queue pass-through).
REQ-015 SHALL drive send_val = (count != 0), purely from registered state and independent of recv_val (no empty-queue bypass).
REQ-016 SHALL drive send_msg combinationally from the head entry; when empty it SHALL drive 0.
REQ-017 SHALL have a latency of exactly 1 cycle: an entry enqueued into an empty queue at edge N is presented with send_val=1 from edge N onward.
REQ-018 SHALL deliver entries in strict FIFO order with no loss or duplication.
REQ-019 SHALL keep head and tail pointers at $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 modulo DEPTH.
REQ-020 SHALL track occupancy in a separate counter: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-021 SHALL, on simultaneous enqueue and dequeue with 0 < count < DEPTH, perform both, leave count unchanged and advance both pointers.
REQ-022 SHALL, when full, ignore recv_val (recv_rdy=0) even if send_rdy=1 in the same cycle; the dequeue SHALL proceed and recv_rdy SHALL rise at the next edge.
REQ-023 SHALL, when empty, not dequeue regardless of send_rdy; send_rdy SHALL have no effect on state.
REQ-024 SHALL not reset storage contents; only the pointers and the counter are reset.
REQ-025 SHALL tolerate X on recv_msg whenever recv_val=0 without corrupting state.

Reset
REQ-026 SHALL, when reset asserts, immediately and independently of clk force head=0, tail=0, count=0, send_val=0, send_msg=0 and recv_rdy=1.
REQ-027 SHALL, on reset asserted mid-operation, discard all held entries; no entry enqueued before reset SHALL appear after reset.
REQ-028 SHALL ignore recv_val and send_rdy while reset is high, and SHALL accept the first enqueue on the first rising edge after reset deasserts.

Verification
REQ-029 Bench SHALL cover basic flow: enqueue 0xA5A5_0001 into an empty queue with send_rdy=0 -> next cycle send_val=1, send_msg=0xA5A5_0001, count=1.
REQ-030 Bench SHALL cover fill: 4 enqueues (0x1..0x4) with send_rdy=0 -> count=4, recv_rdy=0; a 5th recv_val is ignored; draining returns 0x1,0x2,0x3,0x4 in order.
REQ-031 Bench SHALL cover full with simultaneous events: queue full, recv_val=1 and send_rdy=1 -> only the dequeue occurs, count=3, recv_rdy=1 next cycle.
REQ-032 Bench SHALL cover streaming and wrap: recv_val=send_rdy=1 for 10 cycles with count=2 and values 0x10..0x19 -> count stays 2, outputs in order across pointer wrap.
REQ-033 Bench SHALL cover async reset: reset pulsed between clock edges while count=3 -> count=0, send_val=0, recv_rdy=1 before the next edge; a post-reset enqueue of 0x55 is the first value dequeued.
REQ-034 Bench SHALL cover empty dequeue: send_rdy=1 held while empty for 3 cycles -> count stays 0, send_val=0, send_msg=0.
